smart_lane_input_buffer: RTL and testbench
==========================================

# smart_lane_input_buffer

Parametrised multi-lane, credit-based input buffer for one router input port of the SMART mesh. Each lane has its own flit FIFO of configurable depth and width. Every flit that leaves the buffer returns one credit to the upstream router. An optional low-load bypass forwards a flit in the same cycle when its lane is empty and downstream is ready. It sits between the incoming link and the switch-allocation stage, replacing the fixed single-lane register stage.

## Interface
- NUM_LANES, 1: independent lanes (FIFOs) on this port.
- FLIT_WIDTH, 33: flit width in bits; matches FlitFixedData.
- DEPTH, 4: entries per lane FIFO; any value >= 2, power of two not required.
- BYPASS_EN, 1: 1 enables same-cycle empty-lane bypass; 0 always stores.
- CW = $clog2(DEPTH+1): width of each occupancy field.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all lanes.
- in_valid  in  NUM_LANES  flit present on lane i this cycle.
- in_flit  in  NUM_LANES x FLIT_WIDTH  incoming flit per lane.
- out_valid  out  NUM_LANES  lane i head flit available.
- out_flit  out  NUM_LANES x FLIT_WIDTH  lane i head flit.
- out_ready  in  NUM_LANES  downstream consumes lane i when out_valid & out_ready.
- credit_out  out  NUM_LANES  one-cycle pulse per flit dequeued; goes to upstream.
- occupancy  out  NUM_LANES x CW  stored entries per lane; excludes bypassed flits.
- overflow_err  out  NUM_LANES  sticky; a flit arrived with no space.

## Operation
- Lanes are fully independent. There is no arbitration between lanes inside this block.
- Per-lane state: rd_ptr, wr_ptr (0..DEPTH-1, wrap DEPTH-1 -> 0), count (0..DEPTH), storage array.
- Lane i is empty when count = 0.
- **bypass** = BYPASS_EN & empty & in_valid & out_ready.
  - out_flit = in_flit; out_valid = 1.
  - Nothing is written; pointers and count are unchanged.
- **Non-bypass output**: out_valid = (count > 0) | (BYPASS_EN & empty & in_valid).
  - out_flit = storage[rd_ptr] when count > 0, else in_flit.
  - When empty and out_ready = 0, the flit is stored; the pass-through value on out_flit is not consumed.
- **deq** = out_valid & out_ready.
  - A stored dequeue advances rd_ptr.
- **enq** = in_valid & ~bypass.
  - Accepted when count < DEPTH, or when count = DEPTH and a stored dequeue happens the same cycle (full, simultaneous read/write).
  - Accepted: write storage[wr_ptr], advance wr_ptr.
  - Not accepted: the flit is dropped, overflow_err[i] is set (sticky until reset), and count is unchanged.
- **count update**: count_next = count + enq_accepted - stored_deq.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- **Credits**: credit_out[i] is registered and equals deq of the previous cycle. Bypassed flits also return a credit. At most one credit per lane per cycle.
- **flush**:
  - Clears pointers, count and credit_out on the next edge.
  - Clears no overflow_err; returns no credits for discarded flits.
  - Upstream credit counters are re-initialised by the same system event.
  - Input arriving in the flush cycle is discarded.
  - flush has priority over enq/deq.
- occupancy = count (registered state, driven directly).

## Timing
- Reset (rst_n low, asynchronous): count, pointers, credit_out, overflow_err all 0.
  - out_valid is then 0 unless BYPASS_EN and in_valid.
  - Storage contents are don't-care.
- Bypass latency: 0 cycles (combinational in_flit -> out_flit). Stored latency: 1 cycle minimum.
- Credit latency: 1 cycle after the dequeue edge.
- Throughput: 1 flit per lane per cycle, in and out simultaneously, including at full.
- Reset asserted mid-operation discards all stored flits immediately. No credit pulses issue for them.
- The storage array is not reset.

## Test plan
- **Reset**: rst_n low during traffic -> all occupancy = 0, credit_out = 0 and overflow_err = 0 asynchronously; out_valid = 0 with in_valid = 0.
- **Bypass**: BYPASS_EN = 1, lane empty, in_valid = 1, out_ready = 1, flit 0x1_2345_6789 -> out_flit identical the same cycle; occupancy stays 0; credit_out pulses 1 cycle later.
- **Fill and drain**: DEPTH = 4, out_ready = 0, 4 flits A..D -> occupancy 4; then out_ready = 1 -> A, B, C, D in order on consecutive cycles with 4 credit pulses; occupancy ends at 0.
- **Full simultaneous**: count = 4, in_valid and out_ready both high for 3 cycles -> occupancy stays 4, no overflow_err, FIFO order preserved across pointer wrap.
- **Overflow**: count = 4, out_ready = 0, in_valid = 1 -> flit dropped, overflow_err = 1 sticky, occupancy 4; later flits are unaffected.
- **Lane independence and flush**: NUM_LANES = 2, lane 0 stalled at 3 entries while lane 1 streams -> lane 1 unaffected; flush -> both occupancies 0, no credit pulses, overflow_err retained.

Source files
------------

// File: rtl/smart_lane_input_buffer.sv
// Credit-based multi-lane input buffer for one SMART router input port.
// Each lane is an independent FIFO with optional same-cycle bypass when the lane is empty.
module smart_lane_input_buffer #(
  parameter int NUM_LANES  = 1,
  parameter int FLIT_WIDTH = 33,
  parameter int DEPTH      = 4,
  parameter bit BYPASS_EN  = 1'b1,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_LANES-1:0]            in_valid,
  input  logic [NUM_LANES*FLIT_WIDTH-1:0] in_flit,
  output logic [NUM_LANES-1:0]            out_valid,
  output logic [NUM_LANES*FLIT_WIDTH-1:0] out_flit,
  input  logic [NUM_LANES-1:0]            out_ready,
  output logic [NUM_LANES-1:0]            credit_out,
  output logic [NUM_LANES*CW-1:0]         occupancy,
  output logic [NUM_LANES-1:0]            overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : gLane
      logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]         r_rdPtr;
      logic [PW-1:0]         r_wrPtr;
      logic [CW-1:0]         r_count;
      logic                  r_credit;
      logic                  r_overflow;

      logic [FLIT_WIDTH-1:0] w_inFlit;
      logic                  w_empty;
      logic                  w_full;
      logic                  w_bypass;
      logic                  w_outValid;
      logic                  w_deq;
      logic                  w_storedDeq;
      logic                  w_enq;
      logic                  w_accept;

      assign w_inFlit    = in_flit[g*FLIT_WIDTH +: FLIT_WIDTH];
      assign w_empty     = (r_count == '0);
      assign w_full      = (r_count == CW'(DEPTH));
      assign w_bypass    = BYPASS_EN & w_empty & in_valid[g] & out_ready[g];
      assign w_outValid  = ~w_empty | (BYPASS_EN & w_empty & in_valid[g]);
      assign w_deq       = w_outValid & out_ready[g];
      assign w_storedDeq = w_deq & ~w_empty;
      assign w_enq       = in_valid[g] & ~w_bypass;
      // A full lane still accepts when its head leaves in the same cycle.
      assign w_accept    = w_enq & (~w_full | w_storedDeq);

      assign out_valid[g]                         = w_outValid;
      assign out_flit[g*FLIT_WIDTH +: FLIT_WIDTH] = w_empty ? w_inFlit : r_mem[r_rdPtr];
      assign credit_out[g]                        = r_credit;
      assign occupancy[g*CW +: CW]                = r_count;
      assign overflow_err[g]                      = r_overflow;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdPtr    <= '0;
          r_wrPtr    <= '0;
          r_count    <= '0;
          r_credit   <= 1'b0;
          r_overflow <= 1'b0;
        end else if (flush) begin
          r_rdPtr  <= '0;
          r_wrPtr  <= '0;
          r_count  <= '0;
          r_credit <= 1'b0;
        end else begin
          r_credit <= w_deq;
          if (w_storedDeq) r_rdPtr <= nextPtr(r_rdPtr);
          if (w_accept) r_wrPtr <= nextPtr(r_wrPtr);
          if (w_enq && !w_accept) r_overflow <= 1'b1;
          if (w_accept && !w_storedDeq) r_count <= r_count + 1'b1;
          else if (!w_accept && w_storedDeq) r_count <= r_count - 1'b1;
        end
      end

      // Storage carries no reset; occupancy alone says which entries are live.
      always_ff @(posedge clk) begin
        if (w_accept && !flush) r_mem[r_wrPtr] <= w_inFlit;
      end
    end
  endgenerate

endmodule

// File: tb/tb_smart_lane_input_buffer.sv
// Directed self-checking bench for smart_lane_input_buffer with two lanes, depth 4, bypass on.
module tb_smart_lane_input_buffer;
  localparam int NL = 2;
  localparam int FW = 33;
  localparam int DP = 4;
  localparam int CW = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [NL-1:0]    in_valid;
  logic [NL*FW-1:0] in_flit;
  logic [NL-1:0]    out_valid;
  logic [NL*FW-1:0] out_flit;
  logic [NL-1:0]    out_ready;
  logic [NL-1:0]    credit_out;
  logic [NL*CW-1:0] occupancy;
  logic [NL-1:0]    overflow_err;

  int testsRun = 0;
  int testsFailed = 0;
  logic [FW-1:0] q0[$];

  smart_lane_input_buffer #(
    .NUM_LANES(NL), .FLIT_WIDTH(FW), .DEPTH(DP), .BYPASS_EN(1'b1), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_flit(in_flit),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .credit_out(credit_out), .occupancy(occupancy), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] outFlit(input int lane);
    return out_flit[lane*FW +: FW];
  endfunction

  function automatic logic [CW-1:0] occ(input int lane);
    return occupancy[lane*CW +: CW];
  endfunction

  task automatic drive(input int lane, input logic v, input logic [FW-1:0] f, input logic r);
    in_valid[lane] = v;
    in_flit[lane*FW +: FW] = f;
    out_ready[lane] = r;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the falling edge.
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    testsRun++; if (occupancy !== '0) begin testsFailed++; $display("[TB] FAIL reset_occ: got %h want 0", occupancy); end
    testsRun++; if (credit_out !== '0) begin testsFailed++; $display("[TB] FAIL reset_credit: got %b want 0", credit_out); end
    testsRun++; if (overflow_err !== '0) begin testsFailed++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow_err); end
    testsRun++; if (out_valid !== '0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_bypass;
    logic [FW-1:0] f;
    f = 33'h1_2345_6789;
    drive(1, 1'b1, f, 1'b1);
    #1;
    testsRun++; if (out_valid[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL bypass_valid: got %b want 1", out_valid[1]); end
    testsRun++; if (outFlit(1) !== f) begin testsFailed++; $display("[TB] FAIL bypass_flit: got %h want %h", outFlit(1), f); end
    testsRun++; if (credit_out[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL bypass_credit_early: got %b want 0", credit_out[1]); end
    tick;
    drive(1, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (credit_out[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL bypass_credit: got %b want 1", credit_out[1]); end
    testsRun++; if (occ(1) !== 3'd0) begin testsFailed++; $display("[TB] FAIL bypass_occ: got %0d want 0", occ(1)); end
    tick;
    testsRun++; if (credit_out[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL bypass_credit_end: got %b want 0", credit_out[1]); end
  endtask

  task automatic test_fill_drain;
    logic [FW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 33'h0_A000_0000 + FW'(i), 1'b0);
      q0.push_back(33'h0_A000_0000 + FW'(i));
      tick;
    end
    drive(0, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (occ(0) !== 3'd4) begin testsFailed++; $display("[TB] FAIL fill_occ: got %0d want 4", occ(0)); end
    testsRun++; if (credit_out[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_credit: got %b want 0", credit_out[0]); end
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = q0.pop_front();
      #1;
      testsRun++; if (outFlit(0) !== e) begin testsFailed++; $display("[TB] FAIL drain_flit%0d: got %h want %h", i, outFlit(0), e); end
      tick;
      testsRun++; if (credit_out[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL drain_credit%0d: got %b want 1", i, credit_out[0]); end
      testsRun++; if (occ(0) !== CW'(3 - i)) begin testsFailed++; $display("[TB] FAIL drain_occ%0d: got %0d want %0d", i, occ(0), 3 - i); end
    end
    out_ready[0] = 1'b0;
    #1;
    testsRun++; if (out_valid[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_valid: got %b want 0", out_valid[0]); end
    tick;
    testsRun++; if (credit_out[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_credit_end: got %b want 0", credit_out[0]); end
  endtask

  task automatic test_full_simultaneous;
    logic [FW-1:0] n;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 33'h1_E000_0000 + FW'(i), 1'b0);
      q0.push_back(33'h1_E000_0000 + FW'(i));
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      n = 33'h0_B100_0000 + FW'(i);
      drive(0, 1'b1, n, 1'b1);
      #1;
      testsRun++; if (outFlit(0) !== q0[0]) begin testsFailed++; $display("[TB] FAIL full_flit%0d: got %h want %h", i, outFlit(0), q0[0]); end
      tick;
      void'(q0.pop_front());
      q0.push_back(n);
      testsRun++; if (occ(0) !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_occ%0d: got %0d want 4", i, occ(0)); end
      testsRun++; if (credit_out[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_credit%0d: got %b want 1", i, credit_out[0]); end
    end
    drive(0, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (overflow_err[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_ovf: got %b want 0", overflow_err[0]); end
  endtask

  task automatic test_overflow;
    logic [FW-1:0] e;
    logic [FW-1:0] y;
    drive(0, 1'b1, 33'h0_DEAD_BEEF, 1'b0);
    tick;
    drive(0, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (overflow_err[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_set: got %b want 1", overflow_err[0]); end
    testsRun++; if (occ(0) !== 3'd4) begin testsFailed++; $display("[TB] FAIL ovf_occ: got %0d want 4", occ(0)); end
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = q0.pop_front();
      #1;
      testsRun++; if (outFlit(0) !== e) begin testsFailed++; $display("[TB] FAIL ovf_drain%0d: got %h want %h", i, outFlit(0), e); end
      tick;
    end
    out_ready[0] = 1'b0;
    #1;
    testsRun++; if (occ(0) !== 3'd0) begin testsFailed++; $display("[TB] FAIL ovf_drained_occ: got %0d want 0", occ(0)); end
    y = 33'h1_0F0F_0F0F;
    drive(0, 1'b1, y, 1'b0);
    tick;
    drive(0, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (occ(0) !== 3'd1) begin testsFailed++; $display("[TB] FAIL ovf_later_occ: got %0d want 1", occ(0)); end
    testsRun++; if (outFlit(0) !== y) begin testsFailed++; $display("[TB] FAIL ovf_later_flit: got %h want %h", outFlit(0), y); end
    testsRun++; if (overflow_err[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow_err[0]); end
    out_ready[0] = 1'b1;
    tick;
    out_ready[0] = 1'b0;
    #1;
    testsRun++; if (occ(0) !== 3'd0) begin testsFailed++; $display("[TB] FAIL ovf_later_drain: got %0d want 0", occ(0)); end
    testsRun++; if (credit_out[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_later_credit: got %b want 1", credit_out[0]); end
    tick;
  endtask

  task automatic test_lane_flush;
    logic [FW-1:0] s;
    for (int i = 0; i < 3; i++) begin
      s = 33'h0_5500_0000 + FW'(i);
      drive(0, 1'b1, 33'h1_C000_0000 + FW'(i), 1'b0);
      drive(1, 1'b1, s, 1'b1);
      #1;
      testsRun++; if (outFlit(1) !== s || out_valid[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL lane1_flit%0d: got %h want %h", i, outFlit(1), s); end
      tick;
      testsRun++; if (occ(1) !== 3'd0) begin testsFailed++; $display("[TB] FAIL lane1_occ%0d: got %0d want 0", i, occ(1)); end
      testsRun++; if (credit_out !== 2'b10) begin testsFailed++; $display("[TB] FAIL lane_credit%0d: got %b want 10", i, credit_out); end
    end
    drive(0, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (occ(0) !== 3'd3) begin testsFailed++; $display("[TB] FAIL lane0_occ: got %0d want 3", occ(0)); end
    testsRun++; if (outFlit(0) !== 33'h1_C000_0000) begin testsFailed++; $display("[TB] FAIL lane0_head: got %h want 1c0000000", outFlit(0)); end
    flush = 1'b1;
    drive(0, 1'b1, 33'h0_7777_7777, 1'b0);
    drive(1, 1'b1, 33'h0_5500_00FF, 1'b1);
    tick;
    flush = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (occupancy !== '0) begin testsFailed++; $display("[TB] FAIL flush_occ: got %h want 0", occupancy); end
    testsRun++; if (credit_out !== 2'b00) begin testsFailed++; $display("[TB] FAIL flush_credit: got %b want 00", credit_out); end
    testsRun++; if (overflow_err !== 2'b01) begin testsFailed++; $display("[TB] FAIL flush_ovf: got %b want 01", overflow_err); end
    testsRun++; if (out_valid !== 2'b00) begin testsFailed++; $display("[TB] FAIL flush_valid: got %b want 00", out_valid); end
    tick;
    testsRun++; if (credit_out !== 2'b00) begin testsFailed++; $display("[TB] FAIL flush_credit_late: got %b want 00", credit_out); end
    q0.delete();
  endtask

  task automatic test_reset_async;
    drive(0, 1'b1, 33'h0_1111_0000, 1'b0);
    drive(1, 1'b1, 33'h0_2222_0000, 1'b1);
    tick;
    drive(1, 1'b0, '0, 1'b0);
    tick;
    drive(0, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (occ(0) !== 3'd2) begin testsFailed++; $display("[TB] FAIL areset_pre_occ: got %0d want 2", occ(0)); end
    drive(1, 1'b1, 33'h0_2222_0001, 1'b1);
    tick;
    drive(1, 1'b0, '0, 1'b0);
    #1;
    testsRun++; if (credit_out[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL areset_pre_credit: got %b want 1", credit_out[1]); end
    rst_n = 1'b0;
    #1;
    testsRun++; if (occupancy !== '0) begin testsFailed++; $display("[TB] FAIL areset_occ: got %h want 0", occupancy); end
    testsRun++; if (credit_out !== '0) begin testsFailed++; $display("[TB] FAIL areset_credit: got %b want 0", credit_out); end
    testsRun++; if (overflow_err !== '0) begin testsFailed++; $display("[TB] FAIL areset_ovf: got %b want 0", overflow_err); end
    testsRun++; if (out_valid !== '0) begin testsFailed++; $display("[TB] FAIL areset_valid: got %b want 0", out_valid); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '0;
    test_reset();
    test_bypass();
    test_fill_drain();
    test_full_simultaneous();
    test_overflow();
    test_lane_flush();
    test_reset_async();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
